// File: rtl/benes_pkg.sv
// Shared types and widths for the benes16 schedule controller.
package benes_pkg;

   localparam int unsigned LANES = 16;
   localparam int unsigned SEL_W = 7;

   typedef logic [SEL_W-1:0] sel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_e;

endpackage

// File: rtl/benes_cfg_table.sv
// Switch-setting table: DEPTH x SEL_W register file, sync write, async read, sync reset to 0.
module benes_cfg_table
   import benes_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  sel_t          wdata,
   input  logic [AW-1:0] raddr,
   output sel_t          rdata
);

   sel_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/benes16_sched_ctrl.sv
// Sequencer for the 16-lane benes16 network: streams beats through a 2-stage pipeline,
// applying table[ptr] per beat. Define BENES_SCHED_LOOP_EN to loop the schedule until stop.
module benes16_sched_ctrl
   import benes_pkg::*;
#(
   parameter  int unsigned N     = 32,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1,
   localparam int unsigned DW    = LANES * N
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  sel_t          cfg_sel,
   input  logic          start,
   input  logic [CW-1:0] len,
   input  logic          stop,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output sel_t          net_s,
   output logic [DW-1:0] net_x,
   input  logic [DW-1:0] net_y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_idx,
   output logic          busy,
   output logic          done
);

   sched_state_e  state;
   logic [CW-1:0] len_q;
   logic [CW-1:0] cnt;
   logic [AW-1:0] ptr;
   logic [AW-1:0] s1_idx;
   logic          s1_valid;
   logic          adv1, adv2, accept, tbl_we, ptr_last, last_beat;
   sel_t          tbl_rdata;

   assign adv2     = !out_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = (state == RUN) && adv1 && !stop;
   assign accept   = in_valid && in_ready;
   assign tbl_we   = cfg_we && (state == IDLE);
   assign busy     = (state != IDLE);
   assign ptr_last = (CW'(ptr) == len_q - CW'(1));

`ifdef BENES_SCHED_LOOP_EN
   assign last_beat = 1'b0;
`else
   assign last_beat = (cnt == len_q - CW'(1));
`endif

   benes_cfg_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (tbl_we),
      .waddr (cfg_addr),
      .wdata (cfg_sel),
      .raddr (ptr),
      .rdata (tbl_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         len_q     <= '0;
         cnt       <= '0;
         ptr       <= '0;
         s1_idx    <= '0;
         s1_valid  <= 1'b0;
         net_s     <= '0;
         net_x     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;

         case (state)
            IDLE: begin
               if (start && (len != '0) && (len <= CW'(DEPTH))) begin
                  state <= RUN;
                  len_q <= len;
                  ptr   <= '0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               // stop masks in_ready, so a beat offered alongside stop is never taken
               if (stop) begin
                  state <= DRAIN;
               end else if (accept) begin
                  ptr <= ptr_last ? '0 : ptr + AW'(1);
                  cnt <= ptr_last ? '0 : cnt + CW'(1);
                  if (last_beat) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!s1_valid && !out_valid) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // Stage 1 feeds the network; net_s/net_x only move when a beat loads.
         if (adv1) begin
            s1_valid <= accept;
            if (accept) begin
               net_x  <= in_data;
               net_s  <= tbl_rdata;
               s1_idx <= ptr;
            end
         end

         // Stage 2 captures the permuted lanes and holds them under backpressure.
         if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_data <= net_y;
               out_idx  <= s1_idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_benes16_sched_ctrl.sv
// Directed self-checking bench for benes16_sched_ctrl; a lane-reversing, select-xoring stand-in plays benes16.
module tb_benes16_sched_ctrl;
   import benes_pkg::*;

   localparam int unsigned N     = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned CW    = 5;
   localparam int unsigned DW    = 16 * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_we = 1'b0;
   logic [AW-1:0] cfg_addr = '0;
   sel_t          cfg_sel = '0;
   logic          start = 1'b0;
   logic [CW-1:0] len = '0;
   logic          stop = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   sel_t          net_s;
   logic [DW-1:0] net_x;
   logic [DW-1:0] net_y;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_idx;
   logic          busy;
   logic          done;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cnt = 0;

   logic [DW-1:0] oq_data[$];
   logic [AW-1:0] oq_idx[$];
   int            oq_cyc[$];
   sel_t          tbl[DEPTH];

   benes16_sched_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
      .start(start), .len(len), .stop(stop), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .net_s(net_s), .net_x(net_x), .net_y(net_y), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Stand-in network: y[i] = x[15-i] ^ zero-extended select
   always_comb begin
      net_y = '0;
      for (int i = 0; i < 16; i++) net_y[i*N +: N] = net_x[(15-i)*N +: N] ^ 32'(net_s);
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (rst_n && out_valid && out_ready) begin
         oq_data.push_back(out_data);
         oq_idx.push_back(out_idx);
         oq_cyc.push_back(cyc);
      end
   end

   function automatic logic [DW-1:0] mk_beat(input int b);
      logic [DW-1:0] r;
      for (int i = 0; i < 16; i++) r[i*N +: N] = {8'h5A, 8'(b), 8'(i), 8'hC3};
      return r;
   endfunction

   function automatic logic [DW-1:0] exp_out(input int b, input sel_t s);
      logic [DW-1:0] x;
      logic [DW-1:0] r;
      x = mk_beat(b);
      for (int i = 0; i < 16; i++) r[i*N +: N] = x[(15-i)*N +: N] ^ 32'(s);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      oq_data.delete();
      oq_idx.delete();
      oq_cyc.delete();
   endtask

   task automatic write_tbl(input logic [AW-1:0] a, input sel_t s);
      cfg_we = 1'b1; cfg_addr = a; cfg_sel = s;
      tick();
      cfg_we = 1'b0;
      tbl[a] = s;
   endtask

   task automatic start_run(input int l);
      start = 1'b1; len = CW'(l);
      tick();
      start = 1'b0;
   endtask

   task automatic send(input int b, output int acc_cyc);
      bit got = 0;
      acc_cyc = -1;
      in_valid = 1'b1;
      in_data  = mk_beat(b);
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            acc_cyc = cyc;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      tests++;
      if (!got) begin
         fails++;
         $display("FAIL send_beat_%0d: in_ready stayed 0 for 50 cycles, required 1", b);
      end
   endtask

   task automatic wait_idle(input string name);
      bit got = 0;
      for (int c = 0; c < 60 && !got; c++) begin
         @(negedge clk);
         if (!busy) got = 1;
      end
      @(posedge clk);
      #1;
      tests++;
      if (!got) begin
         fails++;
         $display("FAIL %s_idle: busy stayed 1 for 60 cycles, required 0", name);
      end
   endtask

   // In loop builds a run only ends on stop.
   task automatic finish_run(input string name);
`ifdef BENES_SCHED_LOOP_EN
      stop = 1'b1;
      tick();
      stop = 1'b0;
`endif
      wait_idle(name);
   endtask

   task automatic check_queue(input string name, input int n, input int b0, input int idx_mod);
      tests++;
      if (oq_data.size() != n) begin
         fails++;
         $display("FAIL %s_count: got %0d beats, required %0d", name, oq_data.size(), n);
      end
      for (int k = 0; k < n && k < oq_data.size(); k++) begin
         tests++;
         if (oq_idx[k] !== AW'(k % idx_mod)) begin
            fails++;
            $display("FAIL %s_idx[%0d]: got %0d, required %0d", name, k, oq_idx[k], k % idx_mod);
         end
         tests++;
         if (oq_data[k] !== exp_out(b0 + k, tbl[k % idx_mod])) begin
            fails++;
            $display("FAIL %s_data[%0d]: got %h, required %h", name, k, oq_data[k],
                     exp_out(b0 + k, tbl[k % idx_mod]));
         end
      end
   endtask

   task automatic test_reset();
      int a;
      repeat (3) tick();
      @(negedge clk);
      tests++;
      if ({busy, out_valid, done, in_ready} !== 4'b0000 || out_data !== '0 || net_x !== '0 ||
          net_s !== '0 || out_idx !== '0) begin
         fails++;
         $display("FAIL reset_init: busy=%b out_valid=%b done=%b in_ready=%b net_s=%h, required all 0",
                  busy, out_valid, done, in_ready, net_s);
      end
      rst_n = 1'b1;
      tick();
      write_tbl(0, 7'h55);
      write_tbl(1, 7'h2A);
      start_run(4);
      send(100, a);
      send(101, a);
      rst_n = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || net_x !== '0) begin
         fails++;
         $display("FAIL reset_midrun: busy=%b out_valid=%b out_data_nonzero=%b, required 0 0 0",
                  busy, out_valid, |out_data);
      end
      rst_n = 1'b1;
      tick();
      clear_q();
      for (int i = 0; i < int'(DEPTH); i++) tbl[i] = '0;
      start_run(1);
      send(7, a);
      @(negedge clk);
      tests++;
      if (net_s !== 7'h00) begin
         fails++;
         $display("FAIL reset_table: net_s got %h, required 00", net_s);
      end
      finish_run("reset");
      check_queue("reset", 1, 7, 1);
   endtask

   task automatic test_back_to_back();
      int acc[4];
      int d0;
      clear_q();
      d0 = done_cnt;
      write_tbl(0, 7'h00);
      write_tbl(1, 7'h40);
      write_tbl(2, 7'h01);
      write_tbl(3, 7'h3E);
      start_run(4);
      for (int b = 0; b < 4; b++) send(10 + b, acc[b]);
      tests++;
      if (acc[3] - acc[0] != 3) begin
         fails++;
         $display("FAIL b2b_throughput: 4 beats took %0d cycles, required 3", acc[3] - acc[0]);
      end
      finish_run("b2b");
      check_queue("b2b", 4, 10, 4);
      for (int k = 0; k < 4 && k < oq_cyc.size(); k++) begin
         tests++;
         if (oq_cyc[k] - acc[k] != 2) begin
            fails++;
            $display("FAIL b2b_latency[%0d]: got %0d cycles, required 2", k, oq_cyc[k] - acc[k]);
         end
      end
      tests++;
      if (done_cnt - d0 != 1) begin
         fails++;
         $display("FAIL b2b_done: got %0d pulses, required 1", done_cnt - d0);
      end
   endtask

   task automatic test_stall();
      int d0;
      clear_q();
      d0 = done_cnt;
      start_run(4);
      fork
         begin
            int a;
            for (int b = 0; b < 4; b++) send(20 + b, a);
         end
         begin
            bit got = 0;
            for (int c = 0; c < 50 && !got; c++) begin
               @(negedge clk);
               if (out_valid && out_idx == AW'(0)) got = 1;
            end
            tests++;
            if (!got) begin
               fails++;
               $display("FAIL stall_first: beat 0 never appeared, required within 50 cycles");
            end
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               tests++;
               if (out_valid !== 1'b1 || out_idx !== AW'(1) || out_data !== exp_out(21, tbl[1]) ||
                   in_ready !== 1'b0) begin
                  fails++;
                  $display("FAIL stall_hold[%0d]: out_valid=%b idx=%0d in_ready=%b data_ok=%b, required 1 1 0 1",
                           k, out_valid, out_idx, in_ready, out_data === exp_out(21, tbl[1]));
               end
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      finish_run("stall");
      check_queue("stall", 4, 20, 4);
      tests++;
      if (done_cnt - d0 != 1) begin
         fails++;
         $display("FAIL stall_done: got %0d pulses, required 1", done_cnt - d0);
      end
   endtask

   task automatic test_ignored();
      int a;
      int d0;
      start_run(0);
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL len0_start: busy got %b, required 0", busy);
      end
      tick();
      start_run(17);
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL len17_start: busy got %b, required 0", busy);
      end
      tick();
      clear_q();
      d0 = done_cnt;
      start_run(2);
      send(30, a);
      // table write and restart attempted mid-run; neither may take effect
      cfg_we = 1'b1; cfg_addr = 1; cfg_sel = 7'h7F; start = 1'b1; len = CW'(3);
      tick();
      cfg_we = 1'b0; start = 1'b0;
      send(31, a);
      finish_run("ignored");
      check_queue("ignored", 2, 30, 4);
      tests++;
      if (done_cnt - d0 != 1) begin
         fails++;
         $display("FAIL ignored_done: got %0d pulses, required 1", done_cnt - d0);
      end
   endtask

   task automatic test_stop();
      int a;
      int d0;
      clear_q();
      d0 = done_cnt;
      start_run(8);
      send(40, a);
      in_valid = 1'b1;
      in_data  = mk_beat(41);
      stop     = 1'b1;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL stop_ready: in_ready got %b, required 0", in_ready);
      end
      @(posedge clk);
      #1;
      stop = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (busy !== 1'b1 || net_x !== mk_beat(40)) begin
         fails++;
         $display("FAIL stop_drain: busy=%b net_x_ok=%b, required 1 1", busy, net_x === mk_beat(40));
      end
      wait_idle("stop");
      check_queue("stop", 1, 40, 4);
      tests++;
      if (done_cnt - d0 != 1) begin
         fails++;
         $display("FAIL stop_done: got %0d pulses, required 1", done_cnt - d0);
      end
   endtask

`ifdef BENES_SCHED_LOOP_EN
   task automatic test_loop();
      int a;
      int d0;
      clear_q();
      d0 = done_cnt;
      write_tbl(0, 7'h11);
      write_tbl(1, 7'h22);
      write_tbl(2, 7'h33);
      start_run(3);
      for (int b = 0; b < 7; b++) send(50 + b, a);
      repeat (4) tick();
      check_queue("loop", 7, 50, 3);
      tests++;
      if (done_cnt != d0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL loop_running: done pulses %0d busy %b, required 0 1", done_cnt - d0, busy);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("loop");
      tests++;
      if (done_cnt - d0 != 1) begin
         fails++;
         $display("FAIL loop_done: got %0d pulses, required 1", done_cnt - d0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_ignored();
      test_stop();
`ifdef BENES_SCHED_LOOP_EN
      test_loop();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
